// File: rtl/ahb_lite_mem_slave_p.sv
// AHB-Lite memory slave: zero- or fixed-wait OKAY transfers, two-cycle ERROR
// responses for out-of-range / misaligned / oversized accesses, byte-lane writes.
module ahb_lite_mem_slave_p #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp,
  output logic                  error
);
  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NBYTES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * NBYTES);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    dp_valid_q, dp_valid_d;
  logic                    dp_write_q, dp_write_d;
  logic [ADDR_WIDTH-1:0]   dp_addr_q, dp_addr_d;
  logic [2:0]              dp_size_q, dp_size_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    accept;
  logic                    addr_err;
  logic [ADDR_WIDTH-1:0]   align_mask;
  logic [IDX_W-1:0]        dp_idx;
  logic [LANE_BITS-1:0]    dp_off;
  logic [NBYTES-1:0]       byte_en;
  logic                    wr_en;
  logic                    unused_ok;

  assign unused_ok = ^{hburst, hprot, dp_addr_q};

  assign align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
  assign addr_err   = ({1'b0, haddr} >= MEM_LIMIT) ||
                      ((haddr & align_mask) != '0) ||
                      (hsize > 3'(LANE_BITS));
  assign accept     = hsel && hready && htrans[1];

  always_comb begin
    hready     = 1'b1;
    hresp      = 1'b0;
    error      = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_size_d  = dp_size_q;

    case (state_q)
      WAIT: begin
        hready = (cnt_q == 3'd0);
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      end
      ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = ERR2;
      end
      ERR2: begin
        hresp = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase

    // Any cycle with hready high ends the current data phase and may open the next.
    if (hready) begin
      state_d    = IDLE;
      dp_valid_d = 1'b0;
      if (accept) begin
        dp_addr_d  = haddr;
        dp_write_d = hwrite;
        dp_size_d  = hsize;
        if (addr_err) begin
          state_d = ERR1;
        end else begin
          dp_valid_d = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_size_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dp_size_q  <= dp_size_d;
    end
  end

  assign dp_idx = dp_addr_q[LANE_BITS +: IDX_W];
  assign dp_off = dp_addr_q[LANE_BITS-1:0];
  assign wr_en  = dp_valid_q && dp_write_q && hready;

  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NBYTES; i++) begin
      byte_en[i] = (i >= int'(dp_off)) && (i < int'(dp_off) + (1 << dp_size_q));
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (byte_en[i]) mem_q[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Storage is written on the edge that opens the next data phase, so a
  // pipelined read of the same word already sees the merged data here.
  assign hrdata = (dp_valid_q && !dp_write_q && hready) ? mem_q[dp_idx] : '0;

endmodule

// File: tb/tb_ahb_lite_mem_slave_p.sv
// Directed bench: zero-wait instance for data path / errors, 3-wait instance
// for wait-state timing and reset abort.
module tb_ahb_lite_mem_slave_p;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SEQ = 2'd3;

  logic        hclk = 1'b0;
  logic        hreset;
  always #5 hclk = ~hclk;

  logic        hsel, hwrite, hready, hresp, error;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  logic        w_hsel, w_hwrite, w_hready, w_hresp, w_error;
  logic [31:0] w_haddr, w_hwdata, w_hrdata;
  logic [1:0]  w_htrans;
  logic [2:0]  w_hsize;

  int n_tests = 0;
  int n_fail  = 0;
  int lows;
  logic [31:0] rd;

  ahb_lite_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .error(error)
  );

  ahb_lite_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(w_hsel), .haddr(w_haddr), .htrans(w_htrans),
    .hwrite(w_hwrite), .hsize(w_hsize), .hburst(3'd0), .hprot(4'd0), .hwdata(w_hwdata),
    .hrdata(w_hrdata), .hready(w_hready), .hresp(w_hresp), .error(w_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle on the zero-wait instance: drive just after the edge, leave
  // the caller at the following negedge to sample.
  task automatic cyc0(input logic sel, input logic [1:0] t, input logic w,
                      input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    @(posedge hclk); #1;
    hsel = sel; htrans = t; hwrite = w; haddr = a; hsize = s; hwdata = wd;
    @(negedge hclk);
  endtask

  task automatic expect0(input string tag, input logic rdy, input logic resp, input logic err);
    check_eq({tag, ".hready"}, 32'(hready), 32'(rdy));
    check_eq({tag, ".hresp"},  32'(hresp),  32'(resp));
    check_eq({tag, ".error"},  32'(error),  32'(err));
  endtask

  // Single transfer on the 3-wait instance; counts hready-low data-phase cycles.
  task automatic xfer3(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output int n_low, output logic [31:0] rdata);
    @(posedge hclk); #1;
    w_hsel = 1'b1; w_htrans = T_NS; w_hwrite = w; w_haddr = a; w_hsize = 3'd2;
    @(posedge hclk); #1;
    w_htrans = T_IDLE; w_hwrite = 1'b0; w_hwdata = wd;
    n_low = 0;
    rdata = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge hclk);
      if (w_hready) begin
        rdata = w_hrdata;
        break;
      end
      n_low++;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1;
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = '0; hsize = 3'd2; hwdata = '0;
    w_hsel = 1'b0; w_htrans = T_IDLE; w_hwrite = 1'b0; w_haddr = '0; w_hsize = 3'd2; w_hwdata = '0;
    #2;
    expect0("reset", 1'b1, 1'b0, 1'b0);
    check_eq("reset.hrdata", hrdata, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    // Word write then pipelined read of the same word
    cyc0(1, T_NS,   1, 32'h10, 3'd2, 32'h0);
    expect0("wr10.addr", 1'b1, 1'b0, 1'b0);
    cyc0(1, T_NS,   0, 32'h10, 3'd2, 32'hDEADBEEF);
    expect0("wr10.data", 1'b1, 1'b0, 1'b0);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    expect0("rd10", 1'b1, 1'b0, 1'b0);
    check_eq("rd10.hrdata", hrdata, 32'hDEADBEEF);

    // Byte write into upper lane
    cyc0(1, T_NS,   1, 32'h10, 3'd2, 32'h0);
    cyc0(1, T_NS,   1, 32'h13, 3'd0, 32'h11223344);
    cyc0(1, T_NS,   0, 32'h10, 3'd2, 32'hAA000000);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    check_eq("byte13.hrdata", hrdata, 32'hAA223344);

    // Halfword write into upper half
    cyc0(1, T_NS,   1, 32'h14, 3'd2, 32'h0);
    cyc0(1, T_NS,   1, 32'h16, 3'd1, 32'h12345678);
    cyc0(1, T_NS,   0, 32'h14, 3'd2, 32'hBEEF0000);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    check_eq("half16.hrdata", hrdata, 32'hBEEF5678);

    // Last word in range
    cyc0(1, T_NS,   1, 32'h3FC, 3'd2, 32'h0);
    cyc0(1, T_NS,   0, 32'h3FC, 3'd2, 32'h0BADCAFE);
    cyc0(1, T_IDLE, 0, 32'h0,   3'd2, 32'h0);
    check_eq("last.hrdata", hrdata, 32'h0BADCAFE);

    // Write 0x55 then immediate read of the same address
    cyc0(1, T_NS,   1, 32'h20, 3'd2, 32'h0);
    cyc0(1, T_NS,   0, 32'h20, 3'd2, 32'h00000055);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    check_eq("fwd20.hrdata", hrdata, 32'h00000055);

    // Back-to-back NONSEQ/SEQ reads, one per cycle
    cyc0(1, T_NS,   0, 32'h10, 3'd2, 32'h0);
    cyc0(1, T_SEQ,  0, 32'h14, 3'd2, 32'h0);
    expect0("burst0", 1'b1, 1'b0, 1'b0);
    check_eq("burst0.hrdata", hrdata, 32'hAA223344);
    cyc0(1, T_SEQ,  0, 32'h20, 3'd2, 32'h0);
    check_eq("burst1.hrdata", hrdata, 32'hBEEF5678);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    check_eq("burst2.hrdata", hrdata, 32'h00000055);

    // Deselected and BUSY transfers must not touch storage
    cyc0(0, T_NS,   1, 32'h10, 3'd2, 32'h0);
    cyc0(1, T_BUSY, 1, 32'h10, 3'd2, 32'hFFFFFFFF);
    expect0("nosel", 1'b1, 1'b0, 1'b0);
    cyc0(1, T_NS,   0, 32'h10, 3'd2, 32'hFFFFFFFF);
    expect0("busy", 1'b1, 1'b0, 1'b0);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    check_eq("nosel_busy.hrdata", hrdata, 32'hAA223344);

    // Out-of-range read
    cyc0(1, T_NS,   1, 32'h0,   3'd2, 32'h0);
    cyc0(1, T_NS,   0, 32'h400, 3'd2, 32'hCAFEF00D);
    expect0("oor.addr", 1'b1, 1'b0, 1'b0);
    cyc0(1, T_IDLE, 0, 32'h0,   3'd2, 32'h0);
    expect0("oor.err1", 1'b0, 1'b1, 1'b0);
    check_eq("oor.err1.hrdata", hrdata, 32'h0);
    cyc0(1, T_IDLE, 0, 32'h0,   3'd2, 32'h0);
    expect0("oor.err2", 1'b1, 1'b1, 1'b1);
    check_eq("oor.err2.hrdata", hrdata, 32'h0);
    cyc0(1, T_IDLE, 0, 32'h0,   3'd2, 32'h0);
    expect0("oor.idle", 1'b1, 1'b0, 1'b0);

    // Misaligned halfword write; new read accepted during ERR2
    cyc0(1, T_NS,   1, 32'h01, 3'd1, 32'h0);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'hFFFFFFFF);
    expect0("mis.err1", 1'b0, 1'b1, 1'b0);
    cyc0(1, T_NS,   0, 32'h00, 3'd2, 32'hFFFFFFFF);
    expect0("mis.err2", 1'b1, 1'b1, 1'b1);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    expect0("mis.rd", 1'b1, 1'b0, 1'b0);
    check_eq("mis.rd.hrdata", hrdata, 32'hCAFEF00D);

    // Oversized (8-byte) write on a 4-byte bus
    cyc0(1, T_NS,   1, 32'h10, 3'd3, 32'h0);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'hFFFFFFFF);
    expect0("big.err1", 1'b0, 1'b1, 1'b0);
    cyc0(1, T_NS,   0, 32'h10, 3'd2, 32'hFFFFFFFF);
    expect0("big.err2", 1'b1, 1'b1, 1'b1);
    cyc0(1, T_IDLE, 0, 32'h0,  3'd2, 32'h0);
    check_eq("big.rd.hrdata", hrdata, 32'hAA223344);

    // Wait-state instance
    xfer3(1'b1, 32'h08, 32'h13572468, lows, rd);
    check_eq("ws.wr.lows", 32'(lows), 32'd3);
    xfer3(1'b0, 32'h08, 32'h0, lows, rd);
    check_eq("ws.rd.lows", 32'(lows), 32'd3);
    check_eq("ws.rd.hrdata", rd, 32'h13572468);

    // Reset while a write is waiting: aborts without touching storage
    @(posedge hclk); #1;
    w_htrans = T_NS; w_hwrite = 1'b1; w_haddr = 32'h08; w_hsize = 3'd2;
    @(posedge hclk); #1;
    w_htrans = T_IDLE; w_hwrite = 1'b0; w_hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    check_eq("ws.abort.wait", 32'(w_hready), 32'd0);
    #1 hreset = 1'b1;
    #1;
    check_eq("ws.abort.hready", 32'(w_hready), 32'd1);
    check_eq("ws.abort.hresp",  32'(w_hresp),  32'd0);
    check_eq("ws.abort.error",  32'(w_error),  32'd0);
    check_eq("ws.abort.hrdata", w_hrdata,      32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    xfer3(1'b0, 32'h08, 32'h0, lows, rd);
    check_eq("ws.post.lows", 32'(lows), 32'd3);
    check_eq("ws.post.hrdata", rd, 32'h13572468);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_lite_mem_slave_p.md
AHB_LITE_MEM_SLAVE_P -- requirements
Module: ahb_lite_mem_slave_p

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32; bus data width, legal 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32; haddr width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256; storage size in DATA_WIDTH words.
REQ-004 SHALL have parameter WAIT_STATES, default 0; hready-low cycles inserted per OKAY transfer, legal 0..7.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
  hclk  in  1  sole clock, rising edge;
  hreset  in  1  asynchronous, active-high reset;
  hsel  in  1  slave select;
  haddr  in  ADDR_WIDTH  byte address;
  htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3;
  hwrite  in  1  1=write;
  hsize  in  3  transfer size, log2 bytes;
  hburst  in  3  burst type, informational only;
  hprot  in  4  protection, ignored;
  hwdata  in  DATA_WIDTH  write data;
  hrdata  out  DATA_WIDTH  read data;
  hready  out  1  transfer done / slave ready;
  hresp  out  1  0=OKAY, 1=ERROR;
  error  out  1  one-cycle pulse per ERROR response.

Function
REQ-006 SHALL accept an address phase only on a rising edge where hsel=1, hready=1 and htrans is NONSEQ or SEQ; it registers haddr, hwrite and hsize.
REQ-007 IDLE or BUSY transfers, or hsel=0, SHALL produce a zero-wait OKAY data phase with no storage access.
REQ-008 A transfer SHALL be flagged as error when any of the following holds:
  - haddr >= MEM_DEPTH*DATA_WIDTH/8;
  - haddr is not aligned to 2^hsize;
  - 2^hsize > DATA_WIDTH/8.
REQ-009 FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
  - IDLE: hready=1, hresp=0.
  - Accepted OKAY transfer with WAIT_STATES>0 -> WAIT.
  - Accepted error transfer -> ERR1.
REQ-010 WAIT SHALL hold hready=0 for exactly WAIT_STATES cycles using a down-counter, then drive hready=1 for one cycle to complete the transfer.
REQ-011 ERR1 SHALL drive hready=0, hresp=1 for one cycle, then -> ERR2.
REQ-012 ERR2 SHALL drive hready=1, hresp=1 and error=1 for one cycle, then -> IDLE, or accept a new address phase in that cycle.
REQ-013 Writes SHALL update storage on the edge ending an OKAY data phase (hready=1), enabling only the byte lanes selected by haddr low bits and hsize, little-endian.
REQ-014 Errored transfers SHALL never modify storage.
REQ-015 Reads SHALL present the full addressed word on hrdata in the completing data-phase cycle; hrdata SHALL be 0 during ERROR responses.
REQ-016 A read whose address phase overlaps the data phase of a write to the same word SHALL return the merged new data (write-to-read forwarding).
REQ-017 Back-to-back pipelined NONSEQ/SEQ transfers SHALL sustain one transfer per cycle when WAIT_STATES=0.
REQ-018 Storage SHALL be word-indexed by haddr[log2(MEM_DEPTH*DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].

Reset
REQ-019 hreset=1 SHALL immediately force FSM=IDLE, wait counter=0, hready=1, hresp=0, error=0 and hrdata=0.
REQ-020 Reset SHALL abort any in-flight transfer without writing storage; storage contents are not initialised by reset.
REQ-021 After hreset falls, the first address phase SHALL be accepted on the next qualifying edge.

Verification
REQ-022 DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to 0x10 and read back from 0x10 -> hrdata=0xDEADBEEF, hresp=0, no hready-low cycles.
REQ-023 Byte write 0xAA at 0x13 (hsize=0) over word 0x11223344, then read 0x10 -> 0xAA223344.
REQ-024 WAIT_STATES=3: single read -> exactly 3 cycles hready=0, then hready=1 with valid data.
REQ-025 Read at haddr=0x400 (MEM_DEPTH=256), then halfword at 0x01 -> each gives ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1, error=1), storage unchanged.
REQ-026 Write 0x55 to 0x20 immediately followed by a pipelined read of 0x20 -> read returns 0x55; hreset asserted in WAIT -> hready=1 on the same cycle, and a prior read of the target word is unchanged.
